main_mem_resp: RTL
==================

# main_mem_resp

Word-organised main-memory responder for the cache-to-memory request/ready interface. The two-way cache controller drives it as initiator for write-backs and block fills. It services one 32-bit block transfer at a time after a fixed access latency and signals completion with a one-cycle ready pulse. Command fields are evaluated at completion, not at acceptance, so an initiator that holds `req` high across back-to-back transactions is served correctly.

## Interface
- `ADDR_W`, 16: byte-address width; word index is `addr[ADDR_W-1:2]`; depth is 2**(ADDR_W-2) = 16384 words.
- `LATENCY`, 4: edges from acceptance to completion; legal range 2..15.
- `clk` input 1: single clock; all logic on posedge.
- `rstn` input 1: reset, synchronous, active-low.
- `req` input 1: transaction request, level; the initiator holds it high until `rdy`.
- `rw` input 1: 1 = write `din` to memory, 0 = read into `dout`.
- `addr` input ADDR_W: byte address; `addr[1:0]` ignored (block aligned).
- `din` input 32: write block from the initiator.
- `dout` output 32: read block; holds its value between reads.
- `rdy` output 1: completion pulse, exactly one cycle per completed transaction.
- `state` output 3: one-hot FSM state for debug (IDLE = 001, BUSY = 010, DONE = 100).

## Operation
- Storage: `mem[0..16383]` of 32 bits. Word i is initialised to i (zero-extended) at time zero. Reset does not touch the array.
- Reset (rstn = 0 at an edge):
  - state = IDLE, counter = 0, `rdy` = 0, `dout` = 32'h0.
  - Any in-flight transaction is dropped without commit.
- IDLE:
  - `req` = 1 sampled: go to BUSY, counter = LATENCY-1.
  - Otherwise stay in IDLE.
- BUSY, with `req` = 0 sampled (abort): go to IDLE. No write, `dout` unchanged, `rdy` stays 0.
- BUSY, with counter != 0: decrement counter.
- BUSY, with counter == 0 (commit edge): use the `addr`, `rw` and `din` sampled at this edge.
  - Write: `mem[addr[15:2]] <= din`.
  - Read: `dout <= mem[addr[15:2]]`.
  - Then `rdy <= 1` and state = DONE.
- DONE: `rdy <= 0` and return to IDLE unconditionally. `req` is ignored in DONE, including when it stays high.
- Commit-time evaluation is required: the cache still drives `rw` = 1 for one cycle after a write-back `rdy` before switching to a read fill, and no write may result from that cycle.
- Address wrap: none needed; every index within the depth is valid. `addr[1:0]` never affects behaviour.
- A read and a write are never committed on the same edge (only one transaction is in flight).

## Timing
- `req` first sampled high at edge T0 → commit and `rdy` rising at edge T0+LATENCY → `rdy` falling at T0+LATENCY+1.
- Earliest next acceptance is edge T0+LATENCY+2. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- `dout` is valid from the `rdy` rising edge and stable until the next read commit or reset.
- Abort: `req` low at any BUSY edge Tk (T0 < Tk ≤ T0+LATENCY) → IDLE at Tk, no side effects.
- Reset has priority over every transition, including the commit edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then read `addr` = 16'h0010 with LATENCY = 4 → `rdy` high for exactly one cycle at T0+4, `dout` = 32'h00000004, `state` sequence 001→010→100→001.
- Write `addr` = 16'h0123, `din` = 32'hDEADBEEF, then read `addr` = 16'h0120 → `dout` = 32'hDEADBEEF (offset ignored).
- Cache-style write-back then fill:
  - `req` held high throughout.
  - Write A = 16'h0200 with 32'hCAFEF00D.
  - After the `rdy` cycle, keep `rw` = 1 for one cycle, then `rw` = 0 and `addr` = 16'h0040.
  - Expect: the second transaction reads, `dout` = 32'h00000010, `mem[0x80]` = 32'hCAFEF00D, and exactly two `rdy` pulses.
- Abort: write request to 16'h0300; drop `req` at T0+2 → no `rdy`, the following read of 16'h0300 returns 32'h000000C0, `dout` unchanged until then.
- Reset mid-BUSY: `rstn` low at T0+3 of a write → `state` = 001, `rdy` = 0, `dout` = 0, write not committed; the earlier 32'hDEADBEEF is still readable at 16'h0120.
- Boundary: write and read `addr` = 16'hFFFC (word 16383) → round-trips correctly. Rebuild with LATENCY = 2 and confirm `rdy` at T0+2.

Source files
------------

// File: rtl/main_mem_resp.sv
// main_mem_resp: word-organised main-memory responder.
// One 32-bit block transfer is in flight at a time. Completion comes a fixed
// LATENCY edges after acceptance and is flagged by a one-cycle rdy pulse.
// addr, rw and din are sampled on the commit edge, not on the acceptance edge,
// so an initiator that holds req high across transactions is served correctly.
module main_mem_resp #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4      // legal range 2..15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              rdy,
    output logic [2:0]        state
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_BUSY = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [3:0]          w_next_cnt;
    logic                w_commit;
    logic [ADDR_W-3:0]   w_idx;
    logic                w_unused_offset;

    logic [31:0]         r_mem [DEPTH];
    // One flag per word: a clear flag means the word still holds its power-up
    // contents, which are defined as the word's own index.
    logic [DEPTH-1:0]    r_written = '0;

    logic [31:0]         r_dout;
    logic                r_rdy;

    // Blocks are word aligned; the byte offset is deliberately ignored.
    assign w_idx           = addr[ADDR_W-1:2];
    assign w_unused_offset = ^addr[1:0];

    // State and latency counter register; reset wins over every transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic: accept, count down, abort on req low, commit at zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_commit     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next_state = ST_BUSY;
                    w_next_cnt   = 4'(LATENCY - 1);
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_next_cnt = r_cnt - 4'd1;
                end else begin
                    w_commit     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: ready pulse on commit, read data captured on a read commit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdy  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_rdy <= w_commit;
            if (w_commit && !rw) begin
                r_dout <= r_written[w_idx] ? r_mem[w_idx] : 32'(w_idx);
            end
        end
    end

    // Storage write port; a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        // NOTE: the array itself is never reset; only the commit is gated by
        // rstn so an in-flight write is dropped.
        if (rstn && w_commit && rw) begin
            r_mem[w_idx]     <= din;
            r_written[w_idx] <= 1'b1;
        end
    end

    assign dout  = r_dout;
    assign rdy   = r_rdy;
    assign state = r_state;

endmodule
